// File: rtl/mips_store_buffer_if.sv
// Pipeline/memory-port bundle for mips_store_buffer: store port, load port,
// data-memory drive and occupancy status.
interface mips_store_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [5:0]       st_opcode;

  logic             ld_req;
  logic [31:0]      ld_addr;
  logic             ld_grant;

  logic [31:0]      mem_address;
  logic [31:0]      write_data;
  logic [5:0]       mem_opcode;
  logic             sig_mem_read;
  logic             sig_mem_write;

  logic [CNT_W-1:0] sb_count;
  logic             sb_empty;

  // Pipeline side (and memory observer)
  modport master (
    output st_valid, st_addr, st_data, st_opcode, ld_req, ld_addr,
    input  st_ready, ld_grant, mem_address, write_data, mem_opcode,
           sig_mem_read, sig_mem_write, sb_count, sb_empty
  );

  // Store buffer side
  modport slave (
    input  st_valid, st_addr, st_data, st_opcode, ld_req, ld_addr,
    output st_ready, ld_grant, mem_address, write_data, mem_opcode,
           sig_mem_read, sig_mem_write, sb_count, sb_empty
  );
endinterface

// File: rtl/mips_store_buffer.sv
// Posted-write FIFO between the memory stage and mips_data_mem, sharing one
// memory port with loads. Define MIPS_STORE_BUF_BYPASS_EN for empty-buffer store bypass.
module mips_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  mips_store_buffer_if.slave sb
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  opcode;
  } sb_entry_t;

  sb_entry_t        fifo_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_next_c;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic      full_c;
  logic      empty_c;
  logic      legal_c;
  logic      hazard_c;
  logic      drain_c;
  logic      bypass_c;
  logic      push_c;
  sb_entry_t head_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign legal_c = (sb.st_opcode == OP_SB) || (sb.st_opcode == OP_SH) ||
                   (sb.st_opcode == OP_SW);
  assign head_c  = fifo_q[rd_ptr_q];

  assign sb.st_ready = !full_c && !rst;
  assign sb.sb_count = count_q;
  assign sb.sb_empty = empty_c;

  // A same-cycle store is older than the load, so it counts as a hazard too
  always_comb begin
    hazard_c = sb.st_valid && (sb.st_addr == sb.ld_addr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (fifo_q[i].addr == sb.ld_addr)) begin
        hazard_c = 1'b1;
      end
    end
  end

  // Memory-port arbitration: reset, full drain, clean load, hazard drain, drain, bypass
  always_comb begin
    drain_c  = 1'b0;
    bypass_c = 1'b0;
    if (rst) begin
      drain_c = 1'b0;
    end else if (full_c) begin
      drain_c = 1'b1;
    end else if (sb.ld_req && !hazard_c) begin
      drain_c = 1'b0;
    end else if (sb.ld_req) begin
      drain_c = !empty_c;
    end else if (!empty_c) begin
      drain_c = 1'b1;
`ifdef MIPS_STORE_BUF_BYPASS_EN
    end else if (sb.st_valid && legal_c) begin
      bypass_c = 1'b1;
`endif
    end
  end

  assign sb.ld_grant = !rst && !full_c && sb.ld_req && !hazard_c;
  assign push_c      = sb.st_valid && sb.st_ready && legal_c && !bypass_c;

  always_comb begin
    sb.sig_mem_read  = 1'b0;
    sb.sig_mem_write = 1'b0;
    sb.mem_address   = '0;
    sb.write_data    = '0;
    sb.mem_opcode    = '0;
    if (sb.ld_grant) begin
      sb.sig_mem_read = 1'b1;
      sb.mem_address  = sb.ld_addr;
    end else if (drain_c) begin
      sb.sig_mem_write = 1'b1;
      sb.mem_address   = head_c.addr;
      sb.write_data    = head_c.data;
      sb.mem_opcode    = head_c.opcode;
    end else if (bypass_c) begin
      sb.sig_mem_write = 1'b1;
      sb.mem_address   = sb.st_addr;
      sb.write_data    = sb.st_data;
      sb.mem_opcode    = sb.st_opcode;
    end
  end

  // Push and pop never target the same slot: that would need full and empty at once
  always_comb begin
    valid_next_c = valid_q;
    if (drain_c) valid_next_c[rd_ptr_q] = 1'b0;
    if (push_c)  valid_next_c[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      valid_q <= valid_next_c;
      if (push_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (drain_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_c && !drain_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (drain_c && !push_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry payload needs no reset; valid_q qualifies every use
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= '{addr: sb.st_addr, data: sb.st_data, opcode: sb.st_opcode};
    end
  end
endmodule
